cla16_op_responder: RTL
=======================

// Module: cla16_op_responder
// PURPOSE
//  Request/response server for 16-bit add/subtract around CLA_16bit_h. Initiators post
//  {a, b, sub, signed, tag} on a valid/ready request channel. The block runs the operation
//  through the CLA and returns {sum, cout, ovf, tag} on a valid/ready response channel.
//  It also keeps operation and overflow statistics for the ALU datapath.
// PARAMETERS
//  TAG_W    4   width of the opaque request tag, echoed unchanged with the response
//  CNT_W    16  width of the op_count and ovf_count statistics counters
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  req_valid  in   1      request present
//  req_ready  out  1      block accepts the request this cycle
//  req_a      in   16     operand A
//  req_b      in   16     operand B
//  req_sub    in   1      0: A+B, 1: A-B (drives CLA control; CLA cin tied 0)
//  req_signed in   1      1: two's-complement overflow rule, 0: unsigned rule
//  req_tag    in   TAG_W  tag echoed on the response
//  rsp_valid  out  1      response present
//  rsp_ready  in   1      consumer accepts the response this cycle
//  rsp_sum    out  16     result, modulo 2^16
//  rsp_cout   out  1      raw carry-out of A + (sub ? ~B+1 : B)
//  rsp_ovf    out  1      overflow flag, rule below
//  rsp_tag    out  TAG_W  echoed tag
//  clr_stats  in   1      synchronous clear of both counters
//  op_count   out  CNT_W  responses delivered, wraps modulo 2^CNT_W
//  ovf_count  out  CNT_W  delivered responses with ovf=1, saturates at all-ones
// BEHAVIOUR
//  Reset: req_ready=0 during rst and 1 in the first cycle after. rsp_valid=0.
//   rsp_sum/cout/ovf/tag=0. Both counters=0. All in-flight operations are discarded.
//  Handshake: a transfer occurs when valid&&ready on the same edge. Once asserted,
//   req/rsp payloads hold stable until their transfer.
//  Pipeline: stage S1 registers the operands (one-entry skid). Stage S2 registers the CLA
//   result. Latency is exactly 2 cycles from request accept to rsp_valid, with no backpressure.
//  Throughput: 1 op/clk while rsp_ready=1. S2 advances when !rsp_valid || rsp_ready.
//   S1 advances when S2 advances or S1 is empty. req_ready = S1 empty or S1 advancing.
//   With rsp_ready=0 the block holds at most 2 ops, then deasserts req_ready.
//   No op is lost, duplicated or reordered.
//  FSM per stage: EMPTY/FULL valid bit.
//   Simultaneous fill and drain of a stage keeps it FULL with the new entry.
//  Arithmetic: sum = A + (sub ? ~B : B) + sub, truncated to 16 bits. cout = bit 16 of that sum.
//  ovf rules:
//   signed:            (A[15]==B'[15]) && (sum[15]!=A[15]), where B' = sub ? ~B : B.
//   unsigned add:      ovf = cout.
//   unsigned subtract: ovf = !cout (borrow, i.e. A<B).
//   These must equal CLA_16bit_h OF for the same {control, sign}.
//  Counters update only on a response transfer. clr_stats has priority over an increment
//   in the same cycle: the counter result is 0.
//  Reset asserted mid-transfer wins over any handshake on that edge.
// STRUCTURE
//  Shared package (cla16_pkg): req and rsp payload structs, and the localparam WIDTH=16.
//  One sub-module: CLA_16bit_h, instantiated combinationally between S1 and S2.
//   Its cin is tied 0, control=sub, sign=signed.
//  Pipeline control and the counters stay in this module. No other hierarchy.
// TESTING
//  1. Unsigned add, a=0x0002, b=0x0003 -> sum=0x0005, cout=0, ovf=0.
//     Response arrives exactly 2 clks after accept.
//  2. Signed add, 0x4003+0x4002 -> sum=0x8005, cout=0, ovf=1.
//     Signed add, 0xFFFD+0xFFFE -> sum=0xFFFB, cout=1, ovf=0.
//  3. Signed sub, 0x6006-0x800D -> sum=0xDFF9, ovf=1.
//     Unsigned sub, 0x800B-0x0007 -> sum=0x8004, cout=1, ovf=0.
//     Unsigned sub, 0x0003-0x0005 -> ovf=1.
//  4. Back-to-back stream of 8 tagged ops with rsp_ready low for 5 clks mid-stream.
//     req_ready drops after 2 held ops. All 8 tags return in order with correct sums.
//  5. Stats: 3 ovf ops and 2 clean ops -> op_count=5, ovf_count=3.
//     clr_stats coincident with a transfer -> both counters read 0.
//     Preload ovf_count near all-ones -> it saturates.
//  6. Assert rst with 2 ops in flight -> rsp_valid=0 on the next clk, counters=0,
//     no stale response emitted after reset release.

Source files
------------

// File: rtl/cla16_pkg.sv
// rtl/cla16_pkg.sv - shared datapath width and payload structs for the CLA op responder
package cla16_pkg;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             is_signed;
  } op_req_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } op_rsp_t;

endpackage

// File: rtl/CLA_16bit_h.sv
// rtl/CLA_16bit_h.sv - 16-bit carry-lookahead add/subtract with signed/unsigned overflow flag
module CLA_16bit_h
  import cla16_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             control,
  input  logic             sign,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of
);

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [3:0]       gg;
  logic [3:0]       gp;
  logic [4:0]       gc;

  always_comb begin
    bb = control ? ~b : b;
    g  = a & bb;
    p  = a ^ bb;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Subtract adds the +1 of two's complement through the carry-in.
    gc[0] = cin ^ control;
    gc[1] = gg[0] | (gp[0] & gc[0]);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & gc[0]);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]) |
            (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[WIDTH] = gc[4];
    sum  = p ^ c[WIDTH-1:0];
    cout = c[WIDTH];
    of   = sign ? ((a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]))
                : (control ? ~cout : cout);
  end

endmodule

// File: rtl/cla16_op_responder.sv
// rtl/cla16_op_responder.sv - two-stage valid/ready add/sub server around CLA_16bit_h with op statistics
module cla16_op_responder
  import cla16_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_sub,
  input  logic             req_signed,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ovf_count
);

  op_req_t          s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_valid;
  op_rsp_t          s2_rsp;
  logic [WIDTH-1:0] cla_sum;
  logic             cla_cout;
  logic             cla_ovf;
  logic             s2_adv;
  logic             req_fire;
  logic             rsp_fire;

  assign s2_adv    = !rsp_valid || rsp_ready;
  assign req_ready = !rst && (!s1_valid || s2_adv);
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  assign rsp_sum  = s2_rsp.sum;
  assign rsp_cout = s2_rsp.cout;
  assign rsp_ovf  = s2_rsp.ovf;

  CLA_16bit_h u_cla (
    .a       (s1_op.a),
    .b       (s1_op.b),
    .cin     (1'b0),
    .control (s1_op.sub),
    .sign    (s1_op.is_signed),
    .sum     (cla_sum),
    .cout    (cla_cout),
    .of      (cla_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_tag    <= '0;
      rsp_valid <= 1'b0;
      s2_rsp    <= '0;
      rsp_tag   <= '0;
      op_count  <= '0;
      ovf_count <= '0;
    end else begin
      if (s2_adv) begin
        rsp_valid <= s1_valid;
        if (s1_valid) begin
          s2_rsp  <= '{sum: cla_sum, cout: cla_cout, ovf: cla_ovf};
          rsp_tag <= s1_tag;
        end
      end
      // S1 refills in the same cycle it drains, so a full pipe still streams 1 op/clk.
      if (s2_adv || !s1_valid) begin
        s1_valid <= req_fire;
      end
      if (req_fire) begin
        s1_op  <= '{a: req_a, b: req_b, sub: req_sub, is_signed: req_signed};
        s1_tag <= req_tag;
      end
      if (clr_stats) begin
        op_count  <= '0;
        ovf_count <= '0;
      end else if (rsp_fire) begin
        op_count <= op_count + CNT_W'(1);
        if (s2_rsp.ovf && (ovf_count != '1)) begin
          ovf_count <= ovf_count + CNT_W'(1);
        end
      end
    end
  end

endmodule
